// File: rtl/ccu_ctrl_mu_arbiter.sv
// Round-robin arbiter with age-based starvation protection sharing the CCU memory unit.
// Optional macro CCU_MU_ARB_WB_PRIO_EN: write-back ops win over other non-aged requests.
package ccu_ctrl_pkg;
  typedef enum logic [2:0] {
    SEND_AXI_REQ_R            = 3'd0,
    SEND_AXI_REQ_W            = 3'd1,
    SEND_AXI_REQ_WRITE_BACK_R = 3'd2,
    SEND_AXI_REQ_WRITE_BACK_W = 3'd3,
    SEND_READ_SNP_DATA        = 3'd4,
    SEND_WRITE_SNP_DATA       = 3'd5
  } mu_op_e;
endpackage

module ccu_ctrl_mu_arbiter #(
  parameter int unsigned NoReq      = 2,
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned MaxWait    = 15,
  parameter type         slv_req_t  = logic,
  localparam int unsigned MstIdxBits = $clog2(NoMstPorts),
  localparam int unsigned IdxW       = $clog2(NoReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NoReq-1:0]         req_valid_i,
  input  ccu_ctrl_pkg::mu_op_e     req_op_i              [NoReq],
  input  slv_req_t                 req_holder_i          [NoReq],
  input  logic [MstIdxBits-1:0]    req_first_responder_i [NoReq],
  output logic [NoReq-1:0]         req_gnt_o,
  output logic                     mu_req_o,
  output ccu_ctrl_pkg::mu_op_e     mu_op_o,
  output slv_req_t                 mu_holder_o,
  output logic [MstIdxBits-1:0]    mu_first_responder_o,
  input  logic                     mu_gnt_i,
  output logic [IdxW-1:0]          sel_idx_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            locked_q, locked_d;
  logic [CntW-1:0] wait_cnt_q [NoReq];
  logic [CntW-1:0] wait_cnt_d [NoReq];

  logic [NoReq-1:0] aged;
  logic [IdxW-1:0]  aged_idx, any_idx, sel;
  logic             aged_hit, any_hit, gnt;
`ifdef CCU_MU_ARB_WB_PRIO_EN
  logic [NoReq-1:0] wb;
  logic [IdxW-1:0]  wb_idx;
  logic             wb_hit;
`endif

  // Explicit wrap keeps non-power-of-two NoReq in range.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    if (32'(idx) >= NoReq - 1) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [IdxW-1:0] rr_first(input  logic [NoReq-1:0] mask,
                                               input  logic [IdxW-1:0]  ptr,
                                               output logic             found);
    logic [2*NoReq-1:0] rot;
    logic [IdxW-1:0]    idx;
    logic [IdxW-1:0]    res;
    rot   = {mask, mask} >> ptr;
    idx   = ptr;
    res   = ptr;
    found = 1'b0;
    for (int k = 0; k < NoReq; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        res   = idx;
      end
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NoReq; i++) begin
      aged[i] = req_valid_i[i] && (wait_cnt_q[i] == CntMax);
    end
    aged_idx = rr_first(aged, rr_ptr_q, aged_hit);
    any_idx  = rr_first(req_valid_i, rr_ptr_q, any_hit);
  end

`ifdef CCU_MU_ARB_WB_PRIO_EN
  always_comb begin
    for (int i = 0; i < NoReq; i++) begin
      wb[i] = req_valid_i[i] &&
              ((req_op_i[i] == ccu_ctrl_pkg::SEND_AXI_REQ_WRITE_BACK_R) ||
               (req_op_i[i] == ccu_ctrl_pkg::SEND_AXI_REQ_WRITE_BACK_W));
    end
    wb_idx = rr_first(wb, rr_ptr_q, wb_hit);
  end
`endif

  // A held lock pins the selection until the memory unit grants or valid drops.
  always_comb begin
    sel = rr_ptr_q;
    if (locked_q)      sel = lock_idx_q;
    else if (aged_hit) sel = aged_idx;
`ifdef CCU_MU_ARB_WB_PRIO_EN
    else if (wb_hit)   sel = wb_idx;
`endif
    else if (any_hit)  sel = any_idx;
  end

  always_comb begin
    mu_req_o             = req_valid_i[sel];
    mu_op_o              = req_op_i[sel];
    mu_holder_o          = req_holder_i[sel];
    mu_first_responder_o = req_first_responder_i[sel];
    sel_idx_o            = sel;
    gnt                  = mu_req_o && mu_gnt_i;
    req_gnt_o            = '0;
    req_gnt_o[sel]       = gnt;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    locked_d   = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (gnt) begin
      rr_ptr_d = wrap_inc(sel);
    end else if (mu_req_o) begin
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end
    for (int i = 0; i < NoReq; i++) begin
      if (!req_valid_i[i])                  wait_cnt_d[i] = '0;
      else if (gnt && (sel == IdxW'(i)))    wait_cnt_d[i] = '0;
      else if (wait_cnt_q[i] != CntMax)     wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
      for (int i = 0; i < NoReq; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      locked_q   <= locked_d;
      for (int i = 0; i < NoReq; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

endmodule

// File: tb/tb_ccu_ctrl_mu_arbiter.sv
// Directed plus randomized bench for ccu_ctrl_mu_arbiter (NoReq=3, MaxWait=2) against a behavioural model.
module tb_ccu_ctrl_mu_arbiter;
  import ccu_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int MW = 2;
  typedef logic [7:0] holder_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  vld;
  mu_op_e        op   [N];
  holder_t       hold [N];
  logic [1:0]    fr   [N];
  logic          mgnt;
  logic [N-1:0]  gnt;
  logic          mreq;
  mu_op_e        mop;
  holder_t       mhold;
  logic [1:0]    mfr;
  logic [1:0]    sidx;

  int nvec  = 0;
  int nfail = 0;

  int m_ptr;
  int m_lidx;
  bit m_locked;
  int m_wait [N];
  logic [N-1:0] last_gnt;

  always #5 clk = ~clk;

  ccu_ctrl_mu_arbiter #(
    .NoReq(N), .NoMstPorts(4), .MaxWait(MW), .slv_req_t(holder_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld), .req_op_i(op), .req_holder_i(hold),
    .req_first_responder_i(fr),
    .req_gnt_o(gnt), .mu_req_o(mreq), .mu_op_o(mop), .mu_holder_o(mhold),
    .mu_first_responder_o(mfr), .mu_gnt_i(mgnt), .sel_idx_o(sidx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_wb(input mu_op_e o);
    return (o == SEND_AXI_REQ_WRITE_BACK_R) || (o == SEND_AXI_REQ_WRITE_BACK_W);
  endfunction

  // Round-robin search over a candidate set starting at the model pointer.
  function automatic int first_from(input bit [N-1:0] cand);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  function automatic int model_sel();
    bit [N-1:0] aged_set;
    bit [N-1:0] valid_set;
    int r;
    if (m_locked) return m_lidx;
    for (int i = 0; i < N; i++) begin
      aged_set[i]  = vld[i] && (m_wait[i] == MW);
      valid_set[i] = vld[i];
    end
    r = first_from(aged_set);
    if (r >= 0) return r;
`ifdef CCU_MU_ARB_WB_PRIO_EN
    begin
      bit [N-1:0] wb_set;
      for (int i = 0; i < N; i++) wb_set[i] = vld[i] && is_wb(op[i]);
      r = first_from(wb_set);
      if (r >= 0) return r;
    end
`endif
    r = first_from(valid_set);
    if (r >= 0) return r;
    return m_ptr;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lidx = 0; m_locked = 1'b0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    last_gnt = '0;
  endtask

  // Check all outputs against the model, advance the model, then move to the next negedge.
  task automatic cyc(input string tag);
    int s;
    logic exp_req;
    logic [N-1:0] exp_gnt;
    #1;
    s = model_sel();
    exp_req = vld[s];
    exp_gnt = '0;
    if (exp_req && mgnt) exp_gnt[s] = 1'b1;
    chk({tag, ".sel"},  32'(sidx),  32'(s));
    chk({tag, ".req"},  32'(mreq),  32'(exp_req));
    chk({tag, ".gnt"},  32'(gnt),   32'(exp_gnt));
    chk({tag, ".op"},   32'(mop),   32'(op[s]));
    chk({tag, ".hold"}, 32'(mhold), 32'(hold[s]));
    chk({tag, ".fr"},   32'(mfr),   32'(fr[s]));
    last_gnt = exp_gnt;
    for (int i = 0; i < N; i++) begin
      if (!vld[i] || exp_gnt[i]) m_wait[i] = 0;
      else if (m_wait[i] < MW)   m_wait[i] = m_wait[i] + 1;
    end
    if (exp_gnt != '0) begin
      m_ptr = (s + 1) % N;
      m_locked = 1'b0;
    end else if (exp_req) begin
      m_locked = 1'b1;
      m_lidx = s;
    end else begin
      m_locked = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input mu_op_e o, input holder_t h, input logic [1:0] f);
    vld[i] = v; op[i] = o; hold[i] = h; fr[i] = f;
  endtask

  initial begin
    vld = '0; mgnt = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, SEND_AXI_REQ_R, 8'h00, 2'd0);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset.sel", 32'(sidx), 32'd0);
    chk("reset.req", 32'(mreq), 32'd0);
    chk("reset.gnt", 32'(gnt),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single request with the memory unit always granting.
    set_req(0, 1'b1, SEND_AXI_REQ_W, 8'h11, 2'd1);
    mgnt = 1'b1;
    #1 chk("single.gnt_const", 32'(gnt), 32'b001);
    cyc("single");
    vld = '0;
    #1 chk("single.ptr_const", 32'(sidx), 32'd1);
    cyc("idle1");

    // Round-robin with everyone valid.
    set_req(0, 1'b1, SEND_AXI_REQ_R, 8'h20, 2'd0);
    set_req(1, 1'b1, SEND_AXI_REQ_W, 8'h21, 2'd1);
    set_req(2, 1'b1, SEND_READ_SNP_DATA, 8'h22, 2'd2);
    mgnt = 1'b1;
    begin
      logic [N-1:0] rr_exp [4];
      rr_exp[0] = 3'b010; rr_exp[1] = 3'b100; rr_exp[2] = 3'b001; rr_exp[3] = 3'b010;
      for (int k = 0; k < 4; k++) begin
        #1 chk("rr.gnt_const", 32'(gnt), 32'(rr_exp[k]));
        cyc("rr");
      end
    end
    vld = '0;
    cyc("idle2");

    // Lock stability: requester 1 presented and held while requester 0 arrives.
    set_req(1, 1'b1, SEND_AXI_REQ_WRITE_BACK_R, 8'hA5, 2'd3);
    mgnt = 1'b0;
    cyc("lock0");
    set_req(0, 1'b1, SEND_AXI_REQ_R, 8'h5A, 2'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lock.sel_const", 32'(sidx), 32'd1);
      chk("lock.op_const",  32'(mop),  32'(SEND_AXI_REQ_WRITE_BACK_R));
      cyc("lock");
    end
    mgnt = 1'b1;
    #1 chk("lock.release_const", 32'(gnt), 32'b010);
    cyc("lock_gnt");
    vld[1] = 1'b0;
    #1 chk("lock.next_const", 32'(gnt), 32'b001);
    cyc("lock_next");

    // Write-back priority from pointer 0.
    vld = '0;
    set_req(2, 1'b1, SEND_AXI_REQ_R, 8'h33, 2'd2);
    cyc("wb_setup");
    vld[2] = 1'b0;
    set_req(0, 1'b1, SEND_AXI_REQ_R, 8'h40, 2'd0);
    set_req(1, 1'b1, SEND_AXI_REQ_WRITE_BACK_W, 8'h41, 2'd1);
`ifdef CCU_MU_ARB_WB_PRIO_EN
    #1 chk("wb.gnt_const", 32'(gnt), 32'b010);
`else
    #1 chk("wb.gnt_const", 32'(gnt), 32'b001);
`endif
    cyc("wb");
    vld = '0;
    cyc("idle3");

    // Reset while requester 1 holds the lock.
    mgnt = 1'b0;
    set_req(1, 1'b1, SEND_AXI_REQ_W, 8'h51, 2'd1);
    cyc("rlock0");
    set_req(0, 1'b1, SEND_AXI_REQ_R, 8'h50, 2'd0);
    #1 chk("rlock.sel_const", 32'(sidx), 32'd1);
    cyc("rlock1");
    rst_n = 1'b0;
    #1;
    chk("rlock.rst_sel", 32'(sidx), 32'd0);
    chk("rlock.rst_req", 32'(mreq), 32'd1);
    model_reset();
    @(negedge clk);
    vld = 3'b101;
    set_req(2, 1'b1, SEND_WRITE_SNP_DATA, 8'h62, 2'd2);
    rst_n = 1'b1;
    #1 chk("rlock.after_sel", 32'(sidx), 32'd0);

    // Aging: requester 2 waits while requester 0 holds the lock, then jumps the pointer.
    cyc("age1");
    cyc("age2");
    vld = 3'b111;
    mgnt = 1'b1;
    #1 chk("age.gnt0_const", 32'(gnt), 32'b001);
    cyc("age3");
    vld[0] = 1'b0;
    #1 chk("age.gnt2_const", 32'(gnt), 32'b100);
    cyc("age4");

    // Randomized traffic obeying the hold-until-granted protocol.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (vld[i] && !last_gnt[i]) begin
          if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
        end else begin
          set_req(i, 1'($urandom_range(0, 1)), mu_op_e'($urandom_range(0, 5)),
                  8'($urandom), 2'($urandom));
        end
      end
      mgnt = ($urandom_range(0, 9) < 6);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ccu_ctrl_mu_arbiter.md
# ccu_ctrl_mu_arbiter

Shares the single CCU memory unit between `NoReq` requesters, typically the per-transaction snoop/decision FSM slices of the CCU controller. It forwards the winner's `mu_req`/`mu_op`/request-holder/first-responder bundle to the memory unit and returns that unit's grant to the winner. Arbitration is round-robin with age-based starvation protection. The presented selection is held stable until the memory unit grants it.

## Interface
- `NoReq`, default 2: number of requesters, at least 2.
- `NoMstPorts`, default 4: CCU master ports. Sets `MstIdxBits = $clog2(NoMstPorts)`.
- `MaxWait`, default 15: wait-cycle threshold at which a requester becomes aged, at least 1.
- `slv_req_t`, default logic: request-holder type.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: one clock; reset is asynchronous and active-low.
- `req_valid_i`  in  NoReq: per-requester memory-unit request.
- `req_op_i`  in  NoReq × `mu_op_e`: requested operation, from `ccu_ctrl_pkg`.
- `req_holder_i`  in  NoReq × `slv_req_t`: captured core request.
- `req_first_responder_i`  in  NoReq × MstIdxBits: first snoop responder.
- `req_gnt_o`  out  NoReq: one-hot grant.
- `mu_req_o`  out  1: request to the memory unit.
- `mu_op_o`  out  `mu_op_e`: operation of the selected requester.
- `mu_holder_o`  out  `slv_req_t`: holder of the selected requester.
- `mu_first_responder_o`  out  MstIdxBits: first responder of the selected requester.
- `mu_gnt_i`  in  1: memory-unit grant. May depend combinationally on `mu_req_o`.
- `sel_idx_o`  out  $clog2(NoReq): index currently presented.

## Operation
- State:
  - `rr_ptr_q`: round-robin pointer.
  - `locked_q`: lock flag.
  - `lock_idx_q`: locked requester index.
  - `wait_cnt_q[NoReq]`: per-requester wait counters, saturating at `MaxWait`.
  - All reset to 0.
- Aged: requester i is aged when `req_valid_i[i] && wait_cnt_q[i]==MaxWait`.
- Selection when unlocked, searching indices `rr_ptr_q, rr_ptr_q+1, …` modulo NoReq:
  - Class 1: the first aged valid requester.
  - Class 2: otherwise, the first valid requester.
  - Class 2 is refined by the Configuration option.
- Selection when locked: the selected index is `lock_idx_q` regardless of other requesters.
- Outputs:
  - `mu_req_o = req_valid_i[sel]`.
  - `mu_op_o`, `mu_holder_o` and `mu_first_responder_o` are the `sel` entries.
  - `sel_idx_o = sel`.
  - With no valid request: `mu_req_o`=0, `sel_idx_o` = `rr_ptr_q` (or `lock_idx_q` if locked), and the payload is the `sel` entry.
- Grant: `req_gnt_o[sel] = mu_req_o && mu_gnt_i`; every other bit is 0.
- On a grant:
  - `rr_ptr_q` ← (sel+1) mod NoReq. For NoReq not a power of two, the wrap is explicit.
  - `locked_q` ← 0.
  - `wait_cnt_q[sel]` ← 0.
- On `mu_req_o && !mu_gnt_i`: `locked_q` ← 1 and `lock_idx_q` ← sel.
- Requester protocol: keep `req_valid_i` and the payload stable until granted.
  - If the locked requester drops valid, `mu_req_o` falls to 0 and the lock is released on the next edge.
  - `rr_ptr_q` is unchanged in that case.
- Wait counters, per requester i:
  - If valid and not granted: increment, saturating at `MaxWait`.
  - If not valid: clear to 0.
  - Counter width is `$clog2(MaxWait+1)`.
- Simultaneous grant and new arrivals: arrivals compete on the next cycle with the updated pointer.
- Reset mid-operation: lock, pointer and counters clear asynchronously.
  - An in-flight ungranted request is re-arbitrated after reset.
  - Outputs remain combinational functions of the inputs under reset state.

## Timing
- Zero-cycle paths:
  - `req_valid_i`/payload → `mu_*_o`.
  - `mu_gnt_i` → `req_gnt_o`.
- No registered outputs.
- Grant-to-next-grant: back-to-back grants are possible every cycle.
- The memory unit grants only when it is not busy.
- Selection changes take effect only at clock edges following a grant or a lock release. The selection never changes while `mu_req_o` is high and ungranted.
- Starvation bound: a valid requester is granted within `MaxWait + NoReq` memory-unit grants.

## Configuration
- `CCU_MU_ARB_WB_PRIO_EN` defined:
  - Class 2 is split. Non-aged valid requesters whose op is `SEND_AXI_REQ_WRITE_BACK_R` or `SEND_AXI_REQ_WRITE_BACK_W` win over other ops.
  - Each sub-class uses the same round-robin search.
  - Aged requesters still take precedence over both.
- Undefined: all non-aged requests are equal. Pure round-robin applies, plus aging.

## Test plan
- Single request, MU always granting: `req_valid_i`=01, `mu_gnt_i`=1 → `mu_req_o`=1, `req_gnt_o`=01 in the same cycle, `rr_ptr_q`=1.
- Round-robin: both valid for 4 cycles, gnt=1 → grants 01, 10, 01, 10 (NoReq=2). With NoReq=3 and all valid → 001, 010, 100, 001.
- Lock stability, part 1: requester 1 presented, `mu_gnt_i`=0 for 5 cycles while requester 0 asserts → `sel_idx_o` stays 1 and `mu_op_o` stays stable.
- Lock stability, part 2: gnt=1 on cycle 6 → `req_gnt_o`=10, then requester 0 is granted next.
- Aging, NoReq=3, MaxWait=2: requester 2 waits through 2 grants to others → on the next cycle requester 2 is granted ahead of the pointer order.
- Write-back priority, macro defined: requester 0 op `SEND_AXI_REQ_R`, requester 1 op `SEND_AXI_REQ_WRITE_BACK_W`, `rr_ptr_q`=0 → `req_gnt_o`=10. Macro undefined → 01.
- Reset mid-lock: lock on requester 1, assert `rst_ni`=0 → `locked_q`=0 and `rr_ptr_q`=0. After release, with both valid, requester 0 is selected.
